// File: rtl/aes_key_expand.sv
// AES key schedule: expands a 128/192/256-bit key into 60 words, one word per cycle.
// Ports: clk, rst (sync, active-high), start/key_len/key in; busy, done, err, num_rounds, roundkeys out.
module aes_key_expand #(
  parameter int NK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    key_len,
  input  logic [255:0]  key,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [3:0]    num_rounds,
  output logic [1919:0] roundkeys
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_w [60];
  logic [3:0]  r_nk;
  logic [3:0]  r_nr;
  logic [7:0]  r_rcon;
  logic [5:0]  r_i;
  logic [2:0]  r_mod;
  logic [5:0]  r_last;
  logic        r_err;

  logic [3:0]  w_nk;
  logic [3:0]  w_nr;
  logic        w_sup;
  logic        w_accept;
  logic [5:0]  w_ip;
  logic [5:0]  w_ib;
  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic        w_rot_sel;
  logic        w_sub_sel;
  logic [31:0] w_sb_in;
  logic [31:0] w_sb_out;
  logic [31:0] w_t;
  logic [31:0] w_new;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as x^254 (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127, v;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    v    = gf_mul(x127, x127);
    return v
         ^ {v[6:0], v[7]}
         ^ {v[5:0], v[7:6]}
         ^ {v[4:0], v[7:5]}
         ^ {v[3:0], v[7:4]}
         ^ 8'h63;
  endfunction

  always_comb begin
    w_nk = 4'd4;
    w_nr = 4'd10;
    case (key_len)
      2'd1: begin
        w_nk = 4'd6;
        w_nr = 4'd12;
      end
      2'd2: begin
        w_nk = 4'd8;
        w_nr = 4'd14;
      end
      default: begin
        w_nk = 4'd4;
        w_nr = 4'd10;
      end
    endcase
  end

  assign w_sup    = (key_len != 2'd3) && (w_nk <= 4'(NK_MAX));
  assign w_accept = (r_state == S_IDLE) && start && w_sup;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start && w_sup) w_next = S_EXPAND;
      S_EXPAND: if (r_i == r_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_ip   = r_i - 6'd1;
  assign w_ib   = r_i - {2'b00, r_nk};
  assign w_prev = r_w[w_ip];
  assign w_back = r_w[w_ib];

  // r_mod tracks i mod Nk so no divider is needed.
  assign w_rot_sel = (r_mod == 3'd0);
  assign w_sub_sel = (r_nk == 4'd8) && (r_mod == 3'd4);
  assign w_sb_in   = w_rot_sel ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  assign w_sb_out = {sbox(w_sb_in[31:24]), sbox(w_sb_in[23:16]),
                     sbox(w_sb_in[15:8]),  sbox(w_sb_in[7:0])};

  always_comb begin
    w_t = w_prev;
    if (w_rot_sel)
      w_t = w_sb_out ^ {r_rcon, 24'h000000};
    else if (w_sub_sel)
      w_t = w_sb_out;
  end

  assign w_new = w_back ^ w_t;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
      r_nk    <= 4'd4;
      r_nr    <= 4'd0;
      r_rcon  <= 8'h01;
      r_i     <= 6'd0;
      r_mod   <= 3'd0;
      r_last  <= 6'd0;
      for (int g = 0; g < 60; g++)
        r_w[g] <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == S_IDLE) && start && !w_sup;
      if (w_accept) begin
        for (int g = 0; g < 8; g++)
          r_w[g] <= (g < int'(w_nk)) ? key[255-32*g -: 32] : '0;
        for (int g = 8; g < 60; g++)
          r_w[g] <= '0;
        r_nk   <= w_nk;
        r_nr   <= w_nr;
        r_rcon <= 8'h01;
        r_i    <= {2'b00, w_nk};
        r_mod  <= 3'd0;
        r_last <= {w_nr, 2'b11};
      end else if (r_state == S_EXPAND) begin
        r_w[r_i] <= w_new;
        r_i      <= r_i + 6'd1;
        r_mod    <= (r_mod == r_nk[2:0] - 3'd1) ? 3'd0 : r_mod + 3'd1;
        if (w_rot_sel)
          r_rcon <= xtime(r_rcon);
      end
    end
  end

  assign busy       = (r_state == S_EXPAND);
  assign done       = (r_state == S_DONE);
  assign err        = r_err;
  assign num_rounds = r_nr;

  for (genvar g = 0; g < 60; g++) begin : g_pack
    assign roundkeys[1919-32*g -: 32] = r_w[g];
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors plus random keys vs a
// table-driven key schedule model; also reject, reset and back-to-back cases.
module tb_aes_key_expand;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, busy, done, err;
  logic [1:0]    key_len;
  logic [255:0]  key;
  logic [3:0]    num_rounds;
  logic [1919:0] roundkeys;

  logic          rst4, start4, busy4, done4, err4;
  logic [1:0]    key_len4;
  logic [255:0]  key4;
  logic [3:0]    num_rounds4;
  logic [1919:0] roundkeys4;

  aes_key_expand #(.NK_MAX(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .done(done), .err(err),
    .num_rounds(num_rounds), .roundkeys(roundkeys)
  );

  aes_key_expand #(.NK_MAX(4)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .key_len(key_len4), .key(key4),
    .busy(busy4), .done(done4), .err(err4),
    .num_rounds(num_rounds4), .roundkeys(roundkeys4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb [256];
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // S-box table built by walking the generator 3 and its inverse.
  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
            ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] a);
    return {sb[a[31:24]], sb[a[23:16]], sb[a[15:8]], sb[a[7:0]]};
  endfunction

  function automatic logic [1919:0] model(input logic [255:0] k, input int klen);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [1919:0] r;
    int nk, nr;
    nk = 4 + 2 * klen;
    nr = nk + 6;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk-1], 24'h0};
      else if (nk == 8 && i % nk == 4)
        t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 60; i++) r[1919-32*i -: 32] = w[i];
    return r;
  endfunction

  function automatic int first_diff(input logic [1919:0] a, input logic [1919:0] b);
    for (int i = 0; i < 60; i++)
      if (a[1919-32*i -: 32] !== b[1919-32*i -: 32]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rst4 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    rst4 = 1'b0;
  endtask

  // Starts one expansion; cyc counts edges from the sampling edge to done.
  task automatic run_dut(input logic [1:0] kl, input logic [255:0] k,
                         input bit hold, output int cyc, output bit bad);
    start = 1'b1;
    key_len = kl;
    key = k;
    tick();
    cyc = 1;
    bad = 1'b0;
    if (!hold) begin
      start = 1'b0;
      key = {8{$urandom()}};
      key_len = 2'($urandom_range(0, 3));
    end
    while (!done && cyc < 200) begin
      if (!busy || err) bad = 1'b1;
      tick();
      cyc++;
    end
    if (busy || err) bad = 1'b1;
  endtask

  task automatic test_reset();
    start = 1'b1;
    key_len = 2'd0;
    key = {8{$urandom()}};
    do_reset();
    start = 1'b0;
    n_tests++;
    if ({busy, done, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000", {busy, done, err});
    end
    n_tests++;
    if (num_rounds !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_nr: got %0d expected 0", num_rounds);
    end
    n_tests++;
    if (roundkeys !== '0) begin
      n_fail++;
      $display("FAIL reset_rk: nonzero word %0d", first_diff(roundkeys, '0));
    end
    tick();
    n_tests++;
    if ({busy, done, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: got %b expected 000", {busy, done, err});
    end
  endtask

  task automatic test_kat();
    logic [255:0]  kk [3];
    logic [127:0]  krk [3];
    int            kcyc [3] = '{41, 47, 53};
    int            knr  [3] = '{10, 12, 14};
    logic [255:0]  k;
    logic [1919:0] exp_rk, snap;
    int cyc, d;
    bit bad;
    kk[0]  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    kk[1]  = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    kk[2]  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    krk[0] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    krk[1] = 128'he98ba06f448c773c8ecc720401002202;
    krk[2] = 128'hfe4890d1e6188d0b046df344706c631e;
    for (int c = 0; c < 3; c++) begin
      k = kk[c];
      if (c == 0) k[127:0] = {4{$urandom()}};
      if (c == 1) k[63:0]  = {2{$urandom()}};
      run_dut(2'(c), k, 1'b0, cyc, bad);
      n_tests++;
      if (cyc != kcyc[c] || bad) begin
        n_fail++;
        $display("FAIL kat%0d_latency: got %0d (bad=%0b) expected %0d", c, cyc, bad, kcyc[c]);
      end
      n_tests++;
      if (num_rounds !== 4'(knr[c])) begin
        n_fail++;
        $display("FAIL kat%0d_nr: got %0d expected %0d", c, num_rounds, knr[c]);
      end
      n_tests++;
      if (roundkeys[1919-128*knr[c] -: 128] !== krk[c]) begin
        n_fail++;
        $display("FAIL kat%0d_lastrk: got %h expected %h", c,
                 roundkeys[1919-128*knr[c] -: 128], krk[c]);
      end
      exp_rk = model(k, c);
      d = first_diff(roundkeys, exp_rk);
      n_tests++;
      if (d >= 0) begin
        n_fail++;
        $display("FAIL kat%0d_words: word %0d got %h expected %h", c, d,
                 roundkeys[1919-32*d -: 32], exp_rk[1919-32*d -: 32]);
      end
      if (c == 0) begin
        n_tests++;
        if (roundkeys[511:0] !== '0) begin
          n_fail++;
          $display("FAIL kat0_upper_zero: word %0d nonzero", first_diff(roundkeys, '0));
        end
      end
      snap = roundkeys;
      tick();
      n_tests++;
      if ({busy, done, err} !== 3'b000) begin
        n_fail++;
        $display("FAIL kat%0d_done_pulse: got %b expected 000", c, {busy, done, err});
      end
      repeat (3) tick();
      n_tests++;
      if (roundkeys !== snap || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL kat%0d_hold: word %0d changed, busy=%0b", c,
                 first_diff(roundkeys, snap), busy);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]    kl;
    logic [255:0]  k;
    logic [1919:0] exp_rk;
    int cyc, d, nk, nr;
    bit bad;
    for (int n = 0; n < 8; n++) begin
      kl = 2'($urandom_range(0, 2));
      k = {8{$urandom()}};
      nk = 4 + 2 * int'(kl);
      nr = nk + 6;
      run_dut(kl, k, 1'b0, cyc, bad);
      n_tests++;
      if (cyc != 4 * (nr + 1) - nk + 1 || bad) begin
        n_fail++;
        $display("FAIL rand%0d_latency: got %0d (bad=%0b) expected %0d", n, cyc, bad,
                 4 * (nr + 1) - nk + 1);
      end
      exp_rk = model(k, int'(kl));
      d = first_diff(roundkeys, exp_rk);
      n_tests++;
      if (d >= 0 || num_rounds !== 4'(nr)) begin
        n_fail++;
        $display("FAIL rand%0d_words: word %0d nr %0d expected nr %0d", n, d, num_rounds, nr);
      end
      tick();
    end
  endtask

  task automatic test_reject();
    logic [1919:0] snap;
    logic [3:0]    snap_nr;
    logic [255:0]  k;
    int cyc;
    snap = roundkeys;
    snap_nr = num_rounds;
    start = 1'b1;
    key_len = 2'd3;
    key = {8{$urandom()}};
    tick();
    start = 1'b0;
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rej3_err: err=%0b busy=%0b expected err=1 busy=0", err, busy);
    end
    tick();
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b0 || roundkeys !== snap || num_rounds !== snap_nr) begin
      n_fail++;
      $display("FAIL rej3_after: err=%0b busy=%0b nr=%0d word %0d changed", err, busy,
               num_rounds, first_diff(roundkeys, snap));
    end
    for (int kl = 1; kl <= 3; kl++) begin
      snap = roundkeys4;
      start4 = 1'b1;
      key_len4 = 2'(kl);
      key4 = {8{$urandom()}};
      tick();
      start4 = 1'b0;
      n_tests++;
      if (err4 !== 1'b1 || busy4 !== 1'b0) begin
        n_fail++;
        $display("FAIL rej4_len%0d: err=%0b busy=%0b expected err=1 busy=0", kl, err4, busy4);
      end
      tick();
      n_tests++;
      if (err4 !== 1'b0 || busy4 !== 1'b0 || roundkeys4 !== snap) begin
        n_fail++;
        $display("FAIL rej4_len%0d_after: err=%0b busy=%0b", kl, err4, busy4);
      end
    end
    k = {8{$urandom()}};
    start4 = 1'b1;
    key_len4 = 2'd0;
    key4 = k;
    tick();
    start4 = 1'b0;
    cyc = 1;
    while (!done4 && cyc < 200) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc != 41 || num_rounds4 !== 4'd10 || roundkeys4 !== model(k, 0)) begin
      n_fail++;
      $display("FAIL nk4_aes128: latency %0d nr %0d word %0d", cyc, num_rounds4,
               first_diff(roundkeys4, model(k, 0)));
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] k;
    int cyc, seen;
    bit bad;
    start = 1'b1;
    key_len = 2'd2;
    key = {8{$urandom()}};
    tick();
    start = 1'b0;
    repeat (19) tick();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: got %0b expected 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || roundkeys !== '0 || num_rounds !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_abort: busy=%0b nr=%0d word %0d nonzero", busy, num_rounds,
               first_diff(roundkeys, '0));
    end
    seen = 0;
    repeat (60) begin
      if (done) seen++;
      tick();
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_no_done: got %0d done cycles expected 0", seen);
    end
    k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    run_dut(2'd0, k, 1'b1, cyc, bad);
    n_tests++;
    if (cyc != 41 || bad ||
        roundkeys[639:512] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 ||
        roundkeys !== model(k, 0)) begin
      n_fail++;
      $display("FAIL mid_restart: latency %0d bad %0b rk10 %h", cyc, bad, roundkeys[639:512]);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_drop: busy=%0b done=%0b expected 0 0", busy, done);
    end
    tick();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_restart: busy=%0b expected 1", busy);
    end
    start = 1'b0;
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [255:0]  k;
    logic [1919:0] exp_rk;
    int cyc, d;
    bit bad;
    k = {8{$urandom()}};
    run_dut(2'd2, k, 1'b0, cyc, bad);
    n_tests++;
    if (cyc != 53 || bad || roundkeys !== model(k, 2)) begin
      n_fail++;
      $display("FAIL b2b_first: latency %0d bad %0b word %0d", cyc, bad,
               first_diff(roundkeys, model(k, 2)));
    end
    tick();
    k = {8{$urandom()}};
    run_dut(2'd0, k, 1'b0, cyc, bad);
    n_tests++;
    if (cyc != 41 || bad) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d (bad=%0b) expected 41", cyc, bad);
    end
    n_tests++;
    if (roundkeys[511:0] !== '0) begin
      n_fail++;
      $display("FAIL b2b_cleared: word %0d nonzero", first_diff(roundkeys, '0));
    end
    exp_rk = model(k, 0);
    d = first_diff(roundkeys, exp_rk);
    n_tests++;
    if (d >= 0 || num_rounds !== 4'd10) begin
      n_fail++;
      $display("FAIL b2b_words: word %0d nr %0d expected nr 10", d, num_rounds);
    end
  endtask

  initial begin
    init_sbox();
    rst = 1'b1;
    start = 1'b0;
    key_len = 2'd0;
    key = '0;
    rst4 = 1'b1;
    start4 = 1'b0;
    key_len4 = 2'd0;
    key4 = '0;
    test_reset();
    test_kat();
    test_random();
    test_reject();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
